// File: rtl/phase_clkgen.sv
// Machine-cycle clock/phase generator: prescaler strobe, one-hot phase ring,
// fetch flag, stretched run enable and cycle-boundary halt. All outputs are enables.
//
// Ports:
//   clk      system clock
//   rstreq   async active-low reset request
//   div      prescale ratio (tick every div+1 clks)
//   halt     freeze request, honoured at machine-cycle end
//   tick     prescaler strobe
//   phase    one-hot phase ring
//   fch      fetch half of machine cycle
//   cyc_end  last tick of a running machine cycle
//   rst      run enable (0 holds core in reset)
//   halted   ring frozen at phase[0]
module phase_clkgen #(
  parameter int NPHASE   = 8,
  parameter int DIV_W    = 4,
  parameter int RST_HOLD = 4
) (
  input  logic              clk,
  input  logic              rstreq,
  input  logic [DIV_W-1:0]  div,
  input  logic              halt,
  output logic              tick,
  output logic [NPHASE-1:0] phase,
  output logic              fch,
  output logic              cyc_end,
  output logic              rst,
  output logic              halted
);

  localparam int RC_W = $clog2(RST_HOLD + 1);

  logic              s1_q, s2_q;
  logic              rs;
  logic [DIV_W-1:0]  pcnt_q, pcnt_d;
  logic [DIV_W-1:0]  div_q, div_d;
  logic [NPHASE-1:0] phase_q, phase_d;
  logic              halted_q, halted_d;
  logic              rst_q, rst_d;
  logic [RC_W-1:0]   rcnt_q, rcnt_d;
  logic              halt_ev;

  always_ff @(posedge clk or negedge rstreq) begin
    if (!rstreq) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
    end else begin
      s1_q <= 1'b1;
      s2_q <= s1_q;
    end
  end

  assign rs      = s2_q;
  assign tick    = rs & (pcnt_q == div_q);
  assign cyc_end = tick & phase_q[NPHASE-1] & ~halted_q;
  assign fch     = |phase_q[NPHASE/2-1:0];
  assign phase   = phase_q;
  assign rst     = rst_q;
  assign halted  = halted_q;

  // Halt is only honoured once the core is running.
  assign halt_ev = cyc_end & halt & rst_q;

  always_comb begin
    pcnt_d   = pcnt_q;
    div_d    = div_q;
    phase_d  = phase_q;
    halted_d = halted_q;
    rst_d    = rst_q;
    rcnt_d   = rcnt_q;

    // New ratio is latched only on a tick.
    if (tick) begin
      pcnt_d = '0;
      div_d  = div;
    end else if (rs) begin
      pcnt_d = pcnt_q + DIV_W'(1);
    end

    if (tick) begin
      if (halted_q) begin
        // Release leaves ring at bit 0 for a full tick.
        if (!halt) halted_d = 1'b0;
      end else begin
        phase_d = {phase_q[NPHASE-2:0], phase_q[NPHASE-1]};
        if (halt_ev) halted_d = 1'b1;
      end
    end

    if (cyc_end && !rst_q) begin
      if (rcnt_q == RC_W'(RST_HOLD - 1))
        rst_d = 1'b1;
      else
        rcnt_d = rcnt_q + RC_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rstreq) begin
    if (!rstreq) begin
      pcnt_q   <= '0;
      div_q    <= '0;
      phase_q  <= NPHASE'(1);
      halted_q <= 1'b0;
      rst_q    <= 1'b0;
      rcnt_q   <= '0;
    end else begin
      pcnt_q   <= pcnt_d;
      div_q    <= div_d;
      phase_q  <= phase_d;
      halted_q <= halted_d;
      rst_q    <= rst_d;
      rcnt_q   <= rcnt_d;
    end
  end

endmodule

// File: tb/tb_phase_clkgen.sv
// Directed bench for phase_clkgen (NPHASE=8, DIV_W=4, RST_HOLD=4).
// Edge numbering restarts at 0 on each reset release.
module tb_phase_clkgen;

  logic       clk = 1'b0;
  logic       rstreq;
  logic [3:0] div;
  logic       halt;
  logic       tick;
  logic [7:0] phase;
  logic       fch;
  logic       cyc_end;
  logic       rst;
  logic       halted;

  int checks   = 0;
  int failures = 0;

  phase_clkgen #(
    .NPHASE  (8),
    .DIV_W   (4),
    .RST_HOLD(4)
  ) dut (
    .clk    (clk),
    .rstreq (rstreq),
    .div    (div),
    .halt   (halt),
    .tick   (tick),
    .phase  (phase),
    .fch    (fch),
    .cyc_end(cyc_end),
    .rst    (rst),
    .halted (halted)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic nxt();
    @(negedge clk);
  endtask

  // Release reset at a negedge and follow edges 0..40 with div=0.
  // Ends in the cycle after edge 40 (phase bit 7, cyc_end).
  task automatic release_seq(input string name);
    int idx;
    rstreq = 1'b1;
    nxt();
    chk({name, "_e0_tick"}, 32'(tick), 32'd0);
    chk({name, "_e0_phase"}, 32'(phase), 32'd1);
    for (int k = 1; k <= 40; k++) begin
      nxt();
      idx = (k - 1) % 8;
      chk({name, "_tick"}, 32'(tick), 32'd1);
      chk({name, "_phase"}, 32'(phase), 32'(1 << idx));
      chk({name, "_fch"}, 32'(fch), 32'(idx < 4));
      chk({name, "_cyc"}, 32'(cyc_end), 32'(idx == 7));
      chk({name, "_rst"}, 32'(rst), 32'(k >= 33));
      chk({name, "_hlt"}, 32'(halted), 32'd0);
    end
  endtask

  task automatic chk_async(input string name);
    chk({name, "_rst"}, 32'(rst), 32'd0);
    chk({name, "_hlt"}, 32'(halted), 32'd0);
    chk({name, "_tick"}, 32'(tick), 32'd0);
    chk({name, "_phase"}, 32'(phase), 32'd1);
    chk({name, "_fch"}, 32'(fch), 32'd1);
  endtask

  initial begin
    int idx;
    rstreq = 1'b0;
    div    = 4'd0;
    halt   = 1'b0;
    nxt();
    nxt();
    chk_async("por");
    chk("por_cyc", 32'(cyc_end), 32'd0);

    release_seq("rel1");

    // div=2: latched at edge 41, phases of 3 clks
    div = 4'd2;
    for (int j = 0; j < 48; j++) begin
      nxt();
      idx = (j / 3) % 8;
      chk("d2_tick", 32'(tick), 32'(j % 3 == 2));
      chk("d2_phase", 32'(phase), 32'(1 << idx));
      chk("d2_fch", 32'(fch), 32'(idx < 4));
      chk("d2_cyc", 32'(cyc_end),
          32'((j % 3 == 2) && idx == 7));
    end

    // back to div=0 at edge 89, then 0->3 mid-cycle
    div = 4'd0;
    for (int m = 0; m < 3; m++) begin
      nxt();
      chk("d0_tick", 32'(tick), 32'd1);
      chk("d0_phase", 32'(phase), 32'(1 << m));
    end
    div = 4'd3;
    for (int j = 0; j < 20; j++) begin
      nxt();
      idx = 3 + j / 4;
      chk("d3_tick", 32'(tick), 32'(j % 4 == 3));
      chk("d3_phase", 32'(phase), 32'(1 << idx));
      chk("d3_cyc", 32'(cyc_end),
          32'((j % 4 == 3) && idx == 7));
    end

    // div=0 from edge 112; halt at phase bit 3
    div = 4'd0;
    for (int m = 0; m < 4; m++) begin
      nxt();
      chk("h_pre_phase", 32'(phase), 32'(1 << m));
    end
    halt = 1'b1;
    for (int m = 4; m < 8; m++) begin
      nxt();
      chk("h_run_phase", 32'(phase), 32'(1 << m));
      chk("h_run_hlt", 32'(halted), 32'd0);
      chk("h_run_cyc", 32'(cyc_end), 32'(m == 7));
    end
    for (int m = 0; m < 4; m++) begin
      nxt();
      chk("h_frz_phase", 32'(phase), 32'd1);
      chk("h_frz_hlt", 32'(halted), 32'd1);
      chk("h_frz_cyc", 32'(cyc_end), 32'd0);
      chk("h_frz_tick", 32'(tick), 32'd1);
    end
    halt = 1'b0;
    nxt();
    chk("h_rel_hlt", 32'(halted), 32'd0);
    chk("h_rel_phase", 32'(phase), 32'd1);
    for (int m = 1; m <= 5; m++) begin
      nxt();
      chk("h_after_phase", 32'(phase), 32'(1 << m));
    end

    // async reset at phase bit 5, not halted
    rstreq = 1'b0;
    #1;
    chk_async("ar0");
    nxt();
    release_seq("rel2");

    // halt, then async reset while halted
    halt = 1'b1;
    nxt();
    chk("ar1_pre_hlt", 32'(halted), 32'd1);
    chk("ar1_pre_phase", 32'(phase), 32'd1);
    rstreq = 1'b0;
    #1;
    chk_async("ar1");
    nxt();

    // halt held through reset hold: no freeze until rst=1
    release_seq("rel3");
    nxt();
    chk("rel3_post_hlt", 32'(halted), 32'd1);
    chk("rel3_post_phase", 32'(phase), 32'd1);
    chk("rel3_post_rst", 32'(rst), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
